// File: rtl/operand_bus_arbiter_pkg.sv
// Shared definitions for the operand bus arbiter: bus width default,
// requester count and the arbiter FSM state type.
package operand_bus_arbiter_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int NUM_REQ    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_OFFER  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/operand_bus_arbiter_rr_pick4.sv
// Four-way round-robin picker: searches last+1, last+2, last+3, last (mod 4)
// and returns the first requesting index.
module rr_pick4
  import operand_bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any
);

  logic [1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    winner = last;
    any    = 1'b0;
    idx    = last;
    // Offset 4 wraps to 2'(4) = 0, i.e. the last winner is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + 2'(k);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter for a shared operand bus: selects a requester on the
// external 4:1 mux, captures its operand and offers it to the consumer.
module operand_bus_arbiter
  import operand_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [DATA_W-1:0]  mux_data,
  input  logic               dst_ready,
  output logic [1:0]         sel,
  output logic [3:0]         gnt,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  output logic               busy
);

  arb_state_t state;
  logic [1:0] last;
  logic [1:0] pick_idx;
  logic       pick_any;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Completion pulse is decoded from registered state plus the live ready.
  always_comb begin
    gnt = '0;
    if (state == ST_OFFER && dst_ready) gnt[sel] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      last      <= 2'd3;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            sel   <= pick_idx;
            busy  <= 1'b1;
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          out_data  <= mux_data;
          out_valid <= 1'b1;
          state     <= ST_OFFER;
        end
        ST_OFFER: begin
          if (dst_ready) begin
            out_valid <= 1'b0;
            last      <= sel;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Self-checking bench for operand_bus_arbiter: directed vector table,
// hand-written corner sequences and randomized traffic against a
// transfer-level reference model.
module tb_operand_bus_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = '0;
  logic [DW-1:0] mux_data = '0;
  logic          dst_ready = 1'b0;
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  operand_bus_arbiter #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mux_data  (mux_data),
    .dst_ready (dst_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks where the current transfer is in its
  // arbitrate -> capture -> offer life and which requester it belongs to.
  int            m_phase;   // 0 waiting for requests, 1 capturing, 2 offering
  int            m_owner;
  int            m_last;
  logic [DW-1:0] m_data;

  function automatic int rr_winner(input logic [3:0] r, input int last_idx);
    for (int k = 1; k <= 4; k++) begin
      int idx = (last_idx + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = 3; m_data = '0;
  endtask

  task automatic model_check();
    logic [3:0] exp_gnt;
    exp_gnt = (m_phase == 2 && dst_ready) ? 4'(1 << m_owner) : 4'b0;
    check("m_sel",   32'(sel),       32'(m_owner));
    check("m_valid", 32'(out_valid), 32'(m_phase == 2));
    check("m_data",  32'(out_data),  32'(m_data));
    check("m_gnt",   32'(gnt),       32'(exp_gnt));
    check("m_busy",  32'(busy),      32'(m_phase != 0));
  endtask

  task automatic model_update();
    int w;
    case (m_phase)
      0: begin
        w = rr_winner(req, m_last);
        if (w >= 0) begin m_owner = w; m_phase = 1; end
      end
      1: begin m_data = mux_data; m_phase = 2; end
      default: if (dst_ready) begin m_last = m_owner; m_phase = 0; end
    endcase
  endtask

  // Caller is at negedge: check, then advance one edge and settle.
  task automatic finish_cycle();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  // Runs cycles until a gnt pulse appears (bounded) and compares it.
  task automatic wait_gnt(input string name, input logic [3:0] exp, input int budget);
    logic [3:0] g;
    g = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      g = gnt;
      finish_cycle();
      if (g != 0) break;
    end
    check(name, 32'(g), 32'(exp));
  endtask

  typedef struct {
    logic [3:0]    req;
    logic [DW-1:0] mux;
    logic          rdy;
    logic [1:0]    e_sel;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [3:0]    e_gnt;
    logic          e_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Single requester 0 from reset: select, capture 0x5A, grant, return idle.
    vecs[0] = '{4'b0001, 8'h5A, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[1] = '{4'b0001, 8'h5A, 1'b1, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b1};
    vecs[2] = '{4'b0001, 8'h5A, 1'b1, 2'd0, 1'b1, 8'h5A, 4'b0001, 1'b1};
    vecs[3] = '{4'b0000, 8'h33, 1'b1, 2'd0, 1'b0, 8'h5A, 4'b0000, 1'b0};
    vecs[4] = '{4'b0000, 8'h44, 1'b0, 2'd0, 1'b0, 8'h5A, 4'b0000, 1'b0};

    // Reset state, checked while reset is still asserted.
    model_reset();
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_sel",   32'(sel),       32'd0);
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req = vecs[i].req; mux_data = vecs[i].mux; dst_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_sel", i),   32'(sel),       32'(vecs[i].e_sel));
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_data", i),  32'(out_data),  32'(vecs[i].e_data));
      check($sformatf("v%0d_gnt", i),   32'(gnt),       32'(vecs[i].e_gnt));
      check($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
      finish_cycle();
    end

    // All four requesting: strict rotation starting after requester 0.
    req = 4'b1111; dst_ready = 1'b1; mux_data = 8'hC3;
    wait_gnt("rot_1", 4'b0010, 6);
    wait_gnt("rot_2", 4'b0100, 6);
    wait_gnt("rot_3", 4'b1000, 6);
    wait_gnt("rot_0", 4'b0001, 6);
    wait_gnt("rot_1b", 4'b0010, 6);

    // Stall: operand stays at its captured value while the mux moves on.
    req = 4'b0100; dst_ready = 1'b0; mux_data = 8'h11;
    tick(); tick();
    req = 4'b0000; mux_data = 8'h22;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check("stall_data", 32'(out_data), 32'h11);
    check("stall_gnt",  32'(gnt),      32'd0);
    finish_cycle();
    dst_ready = 1'b1;
    wait_gnt("stall_release", 4'b0100, 3);

    // last is now 2: requesters 3, 0, 1 in that order.
    req = 4'b1011;
    wait_gnt("rr_3", 4'b1000, 6);
    wait_gnt("rr_0", 4'b0001, 6);
    wait_gnt("rr_1", 4'b0010, 6);

    // Request dropped after selection still completes; idle stays idle.
    req = 4'b0010; dst_ready = 1'b1; mux_data = 8'h77;
    tick();
    req = 4'b0000;
    wait_gnt("drop_gnt", 4'b0010, 4);
    tick(); tick();
    check("drop_idle", 32'(busy), 32'd0);

    // Reset while offering: transfer dropped, no pulse, priority back to 0.
    req = 4'b0100; dst_ready = 1'b0; mux_data = 8'h9E;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_offer_valid", 32'(out_valid), 32'd0);
    check("rst_offer_gnt",   32'(gnt),       32'd0);
    check("rst_offer_busy",  32'(busy),      32'd0);
    model_reset();
    dst_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_gnt", 32'(gnt), 32'd0);
    req = 4'b1001;
    rst_n = 1'b1;
    wait_gnt("post_rst_0", 4'b0001, 6);
    wait_gnt("post_rst_3", 4'b1000, 6);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req       = 4'($urandom_range(0, 15));
      mux_data  = 8'($urandom);
      dst_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_bus_arbiter.md
OPERAND_BUS_ARBITER -- requirements
Module: operand_bus_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, width of the shared operand bus; 4 requesters fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req  in  4  per-requester request; bit i held high until gnt[i] seen.
REQ-005 mux_data  in  DATA_W  output of the external 4:1 operand mux, combinational on sel.
REQ-006 dst_ready  in  1  consumer (accumulator datapath) accepts out_data this cycle.
REQ-007 sel  out  2  registered select driven to the external 4:1 mux.
REQ-008 gnt  out  4  one-hot completion pulse to the requester whose data was accepted.
REQ-009 out_data  out  DATA_W  captured operand presented to the consumer.
REQ-010 out_valid  out  1  out_data valid; held until dst_ready.
REQ-011 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-012 FSM SHALL have states IDLE, SAMPLE, OFFER; encoding local to the block.
REQ-013 IDLE: if req!=0, SHALL choose winner by round-robin, load sel, go SAMPLE; else stay IDLE, sel unchanged.
REQ-014 Round-robin search order SHALL be last+1, last+2, last+3, last (mod 4), last = most recently granted index.
REQ-015 SAMPLE: SHALL capture mux_data into out_data, set out_valid, go OFFER (one cycle, unconditional).
REQ-016 OFFER: out_valid and out_data SHALL stay stable until dst_ready=1.
REQ-017 Handshake (OFFER and dst_ready=1) SHALL, same cycle, assert gnt[sel] combinationally from registered state; gnt=0 in all other cycles.
REQ-018 Next edge after handshake: out_valid SHALL clear, last SHALL take sel, FSM SHALL go IDLE.
REQ-019 Latency: req sampled in IDLE at edge N -> sel valid after N, out_valid after N+1; minimum 3 cycles per transfer.
REQ-020 Requester deasserting req[sel] after selection SHALL NOT abort; transfer and gnt pulse still complete.
REQ-021 New requests arriving in SAMPLE/OFFER SHALL be ignored until IDLE; no queuing.
REQ-022 Single active requester SHALL be granted repeatedly, once per 3-cycle minimum period.
REQ-023 All four requesting continuously SHALL be granted in order strictly cycling, no requester waiting more than 3 transfers.
REQ-024 dst_ready in IDLE or SAMPLE SHALL have no effect.
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 rst_n low SHALL immediately force: FSM IDLE, sel=0, out_data=0, out_valid=0, gnt=0, busy=0, last=3.
REQ-027 last=3 after reset SHALL make requester 0 highest priority for the first arbitration.
REQ-028 Reset asserted in SAMPLE or OFFER SHALL drop the transfer without a gnt pulse.
REQ-029 Release of rst_n SHALL take effect at the first rising clk edge after deassertion; no state change while low.

Structure
REQ-030 Shared package SHALL hold DATA_W default, requester count 4, and the FSM state typedef.
REQ-031 Round-robin winner selection SHALL be one sub-module rr_pick4 (inputs req, last; output winner index, any).
REQ-032 The 4:1 operand mux SHALL stay external; this block drives only sel and reads mux_data.
REQ-033 All outputs except gnt SHALL be registered.

Verification
REQ-034 Reset then req=0001, mux_data=0x5A, dst_ready=1 -> sel=0 next cycle, out_data=0x5A with out_valid two cycles after req, gnt=0001 that cycle.
REQ-035 req=1111 held, dst_ready=1 -> gnt sequence 0001,0010,0100,1000,0001, one every 3 cycles.
REQ-036 req=0100, dst_ready=0 for 5 cycles while mux_data changes 0x11->0x22 -> out_data stays 0x11, gnt=0 until dst_ready=1, then gnt=0100.
REQ-037 req=0010 dropped in SAMPLE -> transfer completes, gnt=0010 on handshake; next IDLE with req=0 stays IDLE.
REQ-038 rst_n pulsed low in OFFER -> out_valid=0, gnt never pulses, next arbitration with req=1001 grants requester 0.
REQ-039 last=2, req=1011 -> requester 3 granted, then 0, then 1.
